// File: rtl/svga_timing_pkg.sv
// Default VESA 1024x768@60 raster constants and shared decode helpers.
// Consumed by the svga_timing top as parameter defaults.
package svga_timing_pkg;
    localparam int DEF_H_VIS  = 1024;
    localparam int DEF_H_FP   = 24;
    localparam int DEF_H_SYNC = 136;
    localparam int DEF_H_BP   = 160;
    localparam int DEF_V_VIS  = 768;
    localparam int DEF_V_FP   = 3;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 29;
    localparam logic DEF_H_POL = 1'b0;
    localparam logic DEF_V_POL = 1'b0;

    localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START = DEF_H_VIS + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_VIS + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/svga_timing_if.sv
// Raster output bundle: advance enable in, syncs/blank/coordinates/strobes out.
interface svga_timing_if;
    import svga_timing_pkg::*;
    logic             pix_en;
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic [X_W-1:0]   counter_x;
    logic [Y_W-1:0]   counter_y;
    logic             line_start;
    logic             frame_start;

    modport master (input pix_en,
                    output hsync, vsync, blank, counter_x, counter_y, line_start, frame_start);
    modport slave  (output pix_en,
                    input hsync, vsync, blank, counter_x, counter_y, line_start, frame_start);
endinterface

// File: rtl/svga_timing_mod_counter.sv
// Enable-gated modulo counter 0..MAX; exposes its next value so the
// consumer can register decodes aligned with the count.
module mod_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_tc
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == MAXV);
    assign o_nxt = !i_en ? r_cnt : (o_tc ? '0 : r_cnt + WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!nrst) r_cnt <= '0;
        else       r_cnt <= o_nxt;
    end
endmodule

// File: rtl/svga_timing.sv
// Raster timing generator: two chained modulo counters plus one register
// stage of decodes taken from the counters' next values, so all outputs align.
module svga_timing
    import svga_timing_pkg::*;
#(
    parameter int   H_VIS  = DEF_H_VIS,
    parameter int   H_FP   = DEF_H_FP,
    parameter int   H_SYNC = DEF_H_SYNC,
    parameter int   H_BP   = DEF_H_BP,
    parameter int   V_VIS  = DEF_V_VIS,
    parameter int   V_FP   = DEF_V_FP,
    parameter int   V_SYNC = DEF_V_SYNC,
    parameter int   V_BP   = DEF_V_BP,
    parameter logic H_POL  = DEF_H_POL,
    parameter logic V_POL  = DEF_V_POL
) (
    input  logic           clk,
    input  logic           nrst,
    svga_timing_if.master  bus
);
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 2048 || V_TOTAL > 1024 ||
        H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
        $error("svga_timing: illegal timing parameters");
    end

    logic [X_W-1:0] w_x, w_x_nxt;
    logic [Y_W-1:0] w_y, w_y_nxt;
    logic           w_x_tc, w_y_tc;
    logic           w_y_en;

    // Lines advance only on the enabled cycle where the column wraps.
    assign w_y_en = bus.pix_en & w_x_tc;

    mod_counter #(.WIDTH(X_W), .MAX(H_TOTAL - 1)) u_hcnt (
        .clk(clk), .nrst(nrst), .i_en(bus.pix_en),
        .o_cnt(w_x), .o_nxt(w_x_nxt), .o_tc(w_x_tc)
    );

    mod_counter #(.WIDTH(Y_W), .MAX(V_TOTAL - 1)) u_vcnt (
        .clk(clk), .nrst(nrst), .i_en(w_y_en),
        .o_cnt(w_y), .o_nxt(w_y_nxt), .o_tc(w_y_tc)
    );

    logic w_blank_nxt, w_hs_act, w_vs_act;

    assign w_blank_nxt = (int'(w_x_nxt) >= H_VIS) || (int'(w_y_nxt) >= V_VIS);
    assign w_hs_act    = in_range(int'(w_x_nxt), HS_START, HS_END);
    assign w_vs_act    = in_range(int'(w_y_nxt), VS_START, VS_END);

    logic r_hsync, r_vsync, r_blank, r_line_start, r_frame_start;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else if (bus.pix_en) begin
            r_hsync       <= w_hs_act ? H_POL : ~H_POL;
            r_vsync       <= w_vs_act ? V_POL : ~V_POL;
            r_blank       <= w_blank_nxt;
            // Wrap of x means next x is 0; wrap of both means next (0,0).
            r_line_start  <= w_x_tc;
            r_frame_start <= w_x_tc & w_y_tc;
        end
    end

    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.blank       = r_blank;
    assign bus.counter_x   = w_x;
    assign bus.counter_y   = w_y;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_svga_timing.sv
// Directed bench: default-timing instance for horizontal/enable/reset checks,
// a shrunken inverted-polarity instance for full-frame vertical checks.
module tb_svga_timing;
    logic clk;
    logic nrst_a, nrst_b;
    int   n_chk, n_err;

    svga_timing_if if_a ();
    svga_timing_if if_b ();

    svga_timing u_a (.clk(clk), .nrst(nrst_a), .bus(if_a));

    // H_TOTAL=25 (hsync x 18..20), V_TOTAL=14 (vsync y 9..10), active-high syncs.
    svga_timing #(
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_VIS(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_b (.clk(clk), .nrst(nrst_b), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int mx, my, e, fs_cnt, vs_cnt, vs_x, vs_y;
        logic vs_seen;
        n_chk = 0; n_err = 0;
        nrst_a = 1'b0; nrst_b = 1'b0;
        if_a.pix_en = 1'b1; if_b.pix_en = 1'b1;
        step(2);

        chk("a_rst_x",  int'(if_a.counter_x), 0);
        chk("a_rst_y",  int'(if_a.counter_y), 0);
        chk("a_rst_blank", int'(if_a.blank), 0);
        chk("a_rst_hs", int'(if_a.hsync), 1);
        chk("a_rst_vs", int'(if_a.vsync), 1);
        chk("a_rst_ls", int'(if_a.line_start), 1);
        chk("a_rst_fs", int'(if_a.frame_start), 1);
        chk("b_rst_hs", int'(if_b.hsync), 0);
        chk("b_rst_vs", int'(if_b.vsync), 0);

        nrst_a = 1'b1;
        step(1023);
        chk("a_x1023", int'(if_a.counter_x), 1023);
        chk("a_blank1023", int'(if_a.blank), 0);
        chk("a_fs_off", int'(if_a.frame_start), 0);
        step(1);
        chk("a_x1024", int'(if_a.counter_x), 1024);
        chk("a_blank1024", int'(if_a.blank), 1);
        chk("a_hs1024", int'(if_a.hsync), 1);
        step(23);
        chk("a_hs1047", int'(if_a.hsync), 1);
        step(1);
        chk("a_x1048", int'(if_a.counter_x), 1048);
        chk("a_hs1048", int'(if_a.hsync), 0);
        step(135);
        chk("a_hs1183", int'(if_a.hsync), 0);
        step(1);
        chk("a_hs1184", int'(if_a.hsync), 1);
        step(159);
        chk("a_x1343", int'(if_a.counter_x), 1343);
        chk("a_y_line0", int'(if_a.counter_y), 0);
        chk("a_ls1343", int'(if_a.line_start), 0);
        step(1);
        chk("a_wrap_x", int'(if_a.counter_x), 0);
        chk("a_wrap_y", int'(if_a.counter_y), 1);
        chk("a_wrap_ls", int'(if_a.line_start), 1);
        chk("a_wrap_fs", int'(if_a.frame_start), 0);
        chk("a_wrap_blank", int'(if_a.blank), 0);
        chk("a_wrap_vs", int'(if_a.vsync), 1);

        // Freeze with a strobe high: everything holds.
        if_a.pix_en = 1'b0;
        step(5);
        chk("a_frz_x", int'(if_a.counter_x), 0);
        chk("a_frz_y", int'(if_a.counter_y), 1);
        chk("a_frz_ls", int'(if_a.line_start), 1);

        mx = 0; my = 1;
        for (int i = 0; i < 300; i++) begin
            e = $urandom_range(0, 1);
            if_a.pix_en = e[0];
            step(1);
            if (e != 0) mx++;
            chk("a_rnd_x", int'(if_a.counter_x), mx);
            chk("a_rnd_y", int'(if_a.counter_y), my);
            chk("a_rnd_ls", int'(if_a.line_start), (mx == 0) ? 1 : 0);
            chk("a_rnd_blank", int'(if_a.blank), 0);
        end
        if_a.pix_en = 1'b1;

        // Mid-line reset on the default instance.
        nrst_a = 1'b0;
        step(1);
        nrst_a = 1'b1;
        chk("a_mrst_x", int'(if_a.counter_x), 0);
        chk("a_mrst_y", int'(if_a.counter_y), 0);
        chk("a_mrst_fs", int'(if_a.frame_start), 1);
        chk("a_mrst_ls", int'(if_a.line_start), 1);
        chk("a_mrst_hs", int'(if_a.hsync), 1);
        step(1);
        chk("a_post_x", int'(if_a.counter_x), 1);
        chk("a_post_fs", int'(if_a.frame_start), 0);

        // Small instance: two full frames against a reference model.
        nrst_b = 1'b1;
        mx = 0; my = 0; fs_cnt = 0; vs_cnt = 0; vs_seen = 1'b0; vs_x = -1; vs_y = -1;
        for (int i = 1; i <= 700; i++) begin
            step(1);
            if (mx == 24) begin
                mx = 0;
                my = (my == 13) ? 0 : my + 1;
            end else mx++;
            chk("b_x", int'(if_b.counter_x), mx);
            chk("b_y", int'(if_b.counter_y), my);
            chk("b_hs", int'(if_b.hsync), (mx >= 18 && mx < 21) ? 1 : 0);
            chk("b_vs", int'(if_b.vsync), (my >= 9 && my < 11) ? 1 : 0);
            chk("b_blank", int'(if_b.blank), (mx >= 16 || my >= 8) ? 1 : 0);
            chk("b_ls", int'(if_b.line_start), (mx == 0) ? 1 : 0);
            chk("b_fs", int'(if_b.frame_start), (mx == 0 && my == 0) ? 1 : 0);
            if (if_b.frame_start === 1'b1) fs_cnt++;
            if (i <= 350 && if_b.vsync === 1'b1) vs_cnt++;
            if (!vs_seen && if_b.vsync === 1'b1) begin
                vs_seen = 1'b1;
                vs_x = int'(if_b.counter_x);
                vs_y = int'(if_b.counter_y);
            end
        end
        chk("b_fs_count", fs_cnt, 2);
        chk("b_vs_cycles", vs_cnt, 50);
        chk("b_vs_first_x", vs_x, 0);
        chk("b_vs_first_y", vs_y, 9);

        // Mid-frame reset on the small instance at (7,5).
        nrst_b = 1'b0;
        step(1);
        nrst_b = 1'b1;
        step(132);
        chk("b_pos_x", int'(if_b.counter_x), 7);
        chk("b_pos_y", int'(if_b.counter_y), 5);
        nrst_b = 1'b0;
        step(1);
        nrst_b = 1'b1;
        chk("b_mrst_x", int'(if_b.counter_x), 0);
        chk("b_mrst_y", int'(if_b.counter_y), 0);
        chk("b_mrst_ls", int'(if_b.line_start), 1);
        chk("b_mrst_fs", int'(if_b.frame_start), 1);
        chk("b_mrst_blank", int'(if_b.blank), 0);
        chk("b_mrst_hs", int'(if_b.hsync), 0);
        chk("b_mrst_vs", int'(if_b.vsync), 0);
        step(1);
        chk("b_post_x", int'(if_b.counter_x), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
